// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshakes around the port arbiter.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_be;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [DATA_W-1:0]     dm_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with one transaction
// outstanding; data wins arbitration unless a fetch has waited MAX_WAIT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    state_t      r_state, w_state_next;
    owner_t      r_owner, w_owner_next, w_sel;
    logic [3:0]  r_wait_cnt, w_wait_next;
    logic        w_sel_req;
    logic        w_if_gnt;

    // In IDLE the owner is chosen fresh each cycle; afterwards the latched owner is kept.
    always_comb begin
        w_sel = r_owner;
        if (r_state == ST_IDLE) begin
            if ((r_wait_cnt == WAIT_LIM) && bus.if_req) w_sel = OWN_IF;
            else if (bus.dm_req)                        w_sel = OWN_DM;
            else if (bus.if_req)                        w_sel = OWN_IF;
            else                                        w_sel = OWN_NONE;
        end
        case (w_sel)
            OWN_IF:  w_sel_req = bus.if_req;
            OWN_DM:  w_sel_req = bus.dm_req;
            default: w_sel_req = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_if_gnt      = 1'b0;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;

        if (rst_n) begin
            bus.if_rdata = bus.mem_rdata;
            bus.dm_rdata = bus.mem_rdata;
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_sel_req) begin
                        bus.mem_req = 1'b1;
                        if (w_sel == OWN_DM) begin
                            bus.mem_we    = bus.dm_we;
                            bus.mem_addr  = bus.dm_addr;
                            bus.mem_wdata = bus.dm_wdata;
                            bus.mem_be    = bus.dm_be;
                        end else begin
                            bus.mem_addr  = bus.if_addr;
                        end
                        w_owner_next = w_sel;
                        if (bus.mem_gnt) begin
                            w_if_gnt     = (w_sel == OWN_IF);
                            bus.if_gnt   = (w_sel == OWN_IF);
                            bus.dm_gnt   = (w_sel == OWN_DM);
                            w_state_next = ST_RESP;
                        end else begin
                            w_state_next = ST_HOLD;
                        end
                    end else begin
                        // Nothing to issue, or a held owner withdrew its request.
                        w_owner_next = OWN_NONE;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (bus.mem_rvalid) begin
                        bus.if_rvalid = (r_owner == OWN_IF);
                        bus.dm_rvalid = (r_owner == OWN_DM);
                        w_owner_next  = OWN_NONE;
                        w_state_next  = ST_IDLE;
                    end
                end
                default: begin
                    w_owner_next = OWN_NONE;
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (w_if_gnt)
            w_wait_next = '0;
        else if (bus.if_req && (r_wait_cnt < WAIT_LIM))
            w_wait_next = r_wait_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_NONE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_wait_cnt <= w_wait_next;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single memory port between the instruction-fetch path and the load/store path. Each requester uses a request/grant/response handshake, and the block keeps exactly one transaction outstanding on the memory side. Data accesses have priority over fetches, and a wait counter guarantees that a fetch is eventually served. The block sits between the core (fetch unit and LOAD/STORE datapath) and the unified memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_WAIT, 4, consecutive cycles a fetch may be held off before it gets forced priority; range 1..15
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- if_req  input  1  fetch request; held until if_gnt
- if_addr  input  ADDR_W  fetch address
- if_gnt  output  1  fetch request accepted by memory
- if_rvalid  output  1  fetch data valid (one cycle)
- if_rdata  output  DATA_W  fetch data
- dm_req  input  1  load/store request; held until dm_gnt
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_be  input  DATA_W/8  store byte enables
- dm_gnt  output  1  data request accepted
- dm_rvalid  output  1  load data or store acknowledge valid (one cycle)
- dm_rdata  output  DATA_W  load data; don't-care for stores
- mem_req, mem_we, mem_addr, mem_wdata, mem_be  output  1/1/ADDR_W/DATA_W/DATA_W/8  memory request
- mem_gnt  input  1  memory accepts the request this cycle
- mem_rvalid  input  1  memory response; issued for both reads and writes
- mem_rdata  input  DATA_W  memory read data

## Operation
- State machine: IDLE, HOLD, RESP. Owner register: NONE, IF, or DM.
- **IDLE:** choose an owner combinationally.
  - If wait_cnt == MAX_WAIT and if_req is high, IF wins.
  - Otherwise DM wins if dm_req is high, else IF wins if if_req is high.
  - Drive the winner's fields onto mem_*.
  - If mem_gnt is high: assert the winner's gnt and go to RESP.
  - If mem_gnt is low: latch the owner and go to HOLD.
- **HOLD:** the latched owner's request stays on mem_*; the other requester is not considered.
  - On mem_gnt, assert the owner's gnt and go to RESP.
  - If the owner drops its req (protocol violation), return to IDLE with no grant.
- **RESP:** mem_req = 0.
  - On mem_rvalid, pulse the owner's rvalid with rdata = mem_rdata, clear the owner, and go to IDLE.
  - mem_gnt is ignored in this state.
- **Non-owner outputs:** gnt and rvalid are always 0 for the requester that is not the owner. Its rdata is driven with mem_rdata but is qualified only by its own rvalid.
- **mem_we / mem_wdata / mem_be:** forced to 0 when IF is the owner.
- **wait_cnt** (4 bits):
  - Increments, saturating at MAX_WAIT, on every cycle where if_req is high and if_gnt is low.
  - Cleared on if_gnt.
  - Holds its value while if_req is low.
- **Spurious inputs:** mem_rvalid in IDLE or HOLD is ignored and never forwarded. A simultaneous mem_gnt and mem_rvalid in IDLE grants normally and ignores the rvalid.
- **Reset:** asserting rst_n mid-transaction abandons it. State, owner, and wait_cnt clear immediately. A late mem_rvalid arriving after reset release, in IDLE, is dropped.

## Timing
- **Reset values:** while rst_n is low, every output is 0, regardless of inputs. State = IDLE, owner = NONE, wait_cnt = 0.
- **Request path:** combinational, req to mem_req in the same cycle, with zero-cycle arbitration.
- **Grant path:** combinational, mem_gnt to if_gnt/dm_gnt in the same cycle.
- **Response path:** combinational, mem_rvalid/mem_rdata to the owner's rvalid/rdata in the same cycle.
- **Latency:** with zero-wait memory (gnt same cycle, rvalid next cycle), one transaction takes 2 cycles. Peak throughput is 1 transaction per 2 cycles. A new request may be issued in the cycle after rvalid.
- **Forced fetch priority:** with dm_req held high continuously, a pending fetch is granted no later than the IDLE cycle in which wait_cnt reaches MAX_WAIT.
- **Request hold rule:** requesters hold req and all request fields stable from assertion until gnt. The block does not register request fields.

## Test plan
- **Reset:** rst_n = 0 with if_req = dm_req = 1 → mem_req = 0 and all gnt/rvalid = 0. Release with mem_gnt tied to 1 → dm_gnt in the first cycle.
- **Single load:** dm_req = 1, dm_addr = 0x100, mem_gnt = 1; mem_rvalid the next cycle with mem_rdata = 0xDEADBEEF → dm_gnt at cycle 0, dm_rvalid at cycle 1 with dm_rdata = 0xDEADBEEF, if_rvalid = 0.
- **Simultaneous requests:** if_req = 1 (addr 0x0) and dm_req = 1, dm_we = 1 (addr 0x200, wdata 0x55, be = 0xF) → the store is granted first and mem_we = 1. After its rvalid, the fetch is granted with mem_addr = 0x0, mem_we = 0, mem_be = 0.
- **Starvation:** MAX_WAIT = 4, dm_req held high, if_req held high, zero-wait memory → if_gnt occurs within 4 data transactions, after which wait_cnt = 0.
- **Memory stall:** mem_gnt = 0 for 3 cycles with an IF owner, dm_req rising during the stall → mem_addr stays at the fetch address and dm_gnt stays 0 until the fetch's rvalid. dm_gnt occurs in the next IDLE cycle.
- **Reset mid-operation:** rst_n pulsed low while in RESP; mem_rvalid = 1 one cycle after release → neither if_rvalid nor dm_rvalid is asserted, and state = IDLE.
